// File: rtl/german_system.sv
// german_system: three-node German cache-coherence protocol, one guarded rule evaluated per cycle.
// Latency: a selected rule whose guard holds updates the state on the next rising clock edge.
// Backpressure: none; a false guard or a select of 30/31 leaves every register unchanged.
module german_system (
    input logic       clock,
    input logic       reset,
    input logic [4:0] io_en_a
);

    // Channel / request command encodings
    localparam logic [2:0] CMD_EMPTY  = 3'd0;
    localparam logic [2:0] CMD_REQS   = 3'd1;
    localparam logic [2:0] CMD_REQE   = 3'd2;
    localparam logic [2:0] CMD_INV    = 3'd3;
    localparam logic [2:0] CMD_INVACK = 3'd4;
    localparam logic [2:0] CMD_GNTS   = 3'd5;
    localparam logic [2:0] CMD_GNTE   = 3'd6;

    // Cache line states
    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;

    // Rule numbers (select = rule*3 + node)
    localparam logic [3:0] R_SEND_REQ_S    = 4'd0;
    localparam logic [3:0] R_SEND_REQ_E    = 4'd1;
    localparam logic [3:0] R_RECV_REQ      = 4'd2;
    localparam logic [3:0] R_SEND_INV      = 4'd3;
    localparam logic [3:0] R_SEND_INV_ACK  = 4'd4;
    localparam logic [3:0] R_RECV_INV_ACK  = 4'd5;
    localparam logic [3:0] R_SEND_GNT_S    = 4'd6;
    localparam logic [3:0] R_SEND_GNT_E    = 4'd7;
    localparam logic [3:0] R_RECV_GNT      = 4'd8;
    localparam logic [3:0] R_STORE         = 4'd9;

    // Per-node state, index = node number
    logic [2:0][1:0] cache_state_q, cache_state_d;
    logic [2:0][1:0] cache_data_q,  cache_data_d;
    logic [2:0][2:0] chan1_cmd_q,   chan1_cmd_d;
    logic [2:0][1:0] chan1_data_q,  chan1_data_d;
    logic [2:0][2:0] chan2_cmd_q,   chan2_cmd_d;
    logic [2:0][1:0] chan2_data_q,  chan2_data_d;
    logic [2:0][2:0] chan3_cmd_q,   chan3_cmd_d;
    logic [2:0][1:0] chan3_data_q,  chan3_data_d;
    logic [2:0]      inv_set_q,     inv_set_d;
    logic [2:0]      shr_set_q,     shr_set_d;

    // Directory / global state
    logic [2:0] cur_cmd_q,  cur_cmd_d;
    logic [1:0] cur_ptr_q,  cur_ptr_d;
    logic       ex_gntd_q,  ex_gntd_d;
    logic [1:0] mem_data_q, mem_data_d;
    logic [1:0] aux_data_q, aux_data_d;

    logic [3:0] rule;
    logic [1:0] node;
    logic [1:0] aux_inc;

    // Split the select into a rule number (10 = no rule) and a node index.
    always_comb begin
        rule = 4'(io_en_a / 5'd3);
        node = 2'(io_en_a % 5'd3);
    end

    // Store writes the next value of the auxiliary data counter, wrapping 2 -> 0.
    always_comb begin
        aux_inc = (aux_data_q == 2'd2) ? 2'd0 : aux_data_q + 2'd1;
    end

    // Evaluate the selected rule's guard and compute its atomic update.
    always_comb begin
        cache_state_d = cache_state_q;
        cache_data_d  = cache_data_q;
        chan1_cmd_d   = chan1_cmd_q;
        chan1_data_d  = chan1_data_q;
        chan2_cmd_d   = chan2_cmd_q;
        chan2_data_d  = chan2_data_q;
        chan3_cmd_d   = chan3_cmd_q;
        chan3_data_d  = chan3_data_q;
        inv_set_d     = inv_set_q;
        shr_set_d     = shr_set_q;
        cur_cmd_d     = cur_cmd_q;
        cur_ptr_d     = cur_ptr_q;
        ex_gntd_d     = ex_gntd_q;
        mem_data_d    = mem_data_q;
        aux_data_d    = aux_data_q;

        case (rule)
            R_SEND_REQ_S: begin
                if (chan1_cmd_q[node] == CMD_EMPTY && cache_state_q[node] == ST_I) begin
                    chan1_cmd_d[node] = CMD_REQS;
                end
            end
            R_SEND_REQ_E: begin
                if (chan1_cmd_q[node] == CMD_EMPTY &&
                    (cache_state_q[node] == ST_I || cache_state_q[node] == ST_S)) begin
                    chan1_cmd_d[node] = CMD_REQE;
                end
            end
            R_RECV_REQ: begin
                if (cur_cmd_q == CMD_EMPTY &&
                    (chan1_cmd_q[node] == CMD_REQS || chan1_cmd_q[node] == CMD_REQE)) begin
                    cur_cmd_d         = chan1_cmd_q[node];
                    cur_ptr_d         = node;
                    chan1_cmd_d[node] = CMD_EMPTY;
                    // Every current sharer must be considered for invalidation.
                    inv_set_d         = shr_set_q;
                end
            end
            R_SEND_INV: begin
                if (chan2_cmd_q[node] == CMD_EMPTY && inv_set_q[node] &&
                    (cur_cmd_q == CMD_REQE || (cur_cmd_q == CMD_REQS && ex_gntd_q))) begin
                    chan2_cmd_d[node] = CMD_INV;
                    inv_set_d[node]   = 1'b0;
                end
            end
            R_SEND_INV_ACK: begin
                if (chan2_cmd_q[node] == CMD_INV && chan3_cmd_q[node] == CMD_EMPTY) begin
                    chan2_cmd_d[node] = CMD_EMPTY;
                    chan3_cmd_d[node] = CMD_INVACK;
                    // Only an exclusive owner carries dirty data back to memory.
                    if (cache_state_q[node] == ST_E) begin
                        chan3_data_d[node] = cache_data_q[node];
                    end
                    cache_state_d[node] = ST_I;
                end
            end
            R_RECV_INV_ACK: begin
                if (chan3_cmd_q[node] == CMD_INVACK && cur_cmd_q != CMD_EMPTY) begin
                    chan3_cmd_d[node] = CMD_EMPTY;
                    shr_set_d[node]   = 1'b0;
                    if (ex_gntd_q) begin
                        ex_gntd_d  = 1'b0;
                        mem_data_d = chan3_data_q[node];
                    end
                end
            end
            R_SEND_GNT_S: begin
                if (cur_cmd_q == CMD_REQS && cur_ptr_q == node &&
                    chan2_cmd_q[node] == CMD_EMPTY && !ex_gntd_q) begin
                    chan2_cmd_d[node]  = CMD_GNTS;
                    chan2_data_d[node] = mem_data_q;
                    shr_set_d[node]    = 1'b1;
                    cur_cmd_d          = CMD_EMPTY;
                end
            end
            R_SEND_GNT_E: begin
                if (cur_cmd_q == CMD_REQE && cur_ptr_q == node &&
                    chan2_cmd_q[node] == CMD_EMPTY && !ex_gntd_q && shr_set_q == 3'b000) begin
                    chan2_cmd_d[node]  = CMD_GNTE;
                    chan2_data_d[node] = mem_data_q;
                    shr_set_d[node]    = 1'b1;
                    ex_gntd_d          = 1'b1;
                    cur_cmd_d          = CMD_EMPTY;
                end
            end
            R_RECV_GNT: begin
                if (chan2_cmd_q[node] == CMD_GNTS || chan2_cmd_q[node] == CMD_GNTE) begin
                    cache_state_d[node] = (chan2_cmd_q[node] == CMD_GNTS) ? ST_S : ST_E;
                    cache_data_d[node]  = chan2_data_q[node];
                    chan2_cmd_d[node]   = CMD_EMPTY;
                end
            end
            R_STORE: begin
                if (cache_state_q[node] == ST_E) begin
                    cache_data_d[node] = aux_inc;
                    aux_data_d         = aux_inc;
                end
            end
            default: begin
                // Selects 30 and 31 name no rule.
            end
        endcase
    end

    // State registers; reset clears the whole protocol state at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_state_q <= '0;
            cache_data_q  <= '0;
            chan1_cmd_q   <= '0;
            chan1_data_q  <= '0;
            chan2_cmd_q   <= '0;
            chan2_data_q  <= '0;
            chan3_cmd_q   <= '0;
            chan3_data_q  <= '0;
            inv_set_q     <= '0;
            shr_set_q     <= '0;
            cur_cmd_q     <= CMD_EMPTY;
            cur_ptr_q     <= '0;
            ex_gntd_q     <= 1'b0;
            mem_data_q    <= '0;
            aux_data_q    <= '0;
        end else begin
            cache_state_q <= cache_state_d;
            cache_data_q  <= cache_data_d;
            chan1_cmd_q   <= chan1_cmd_d;
            chan1_data_q  <= chan1_data_d;
            chan2_cmd_q   <= chan2_cmd_d;
            chan2_data_q  <= chan2_data_d;
            chan3_cmd_q   <= chan3_cmd_d;
            chan3_data_q  <= chan3_data_d;
            inv_set_q     <= inv_set_d;
            shr_set_q     <= shr_set_d;
            cur_cmd_q     <= cur_cmd_d;
            cur_ptr_q     <= cur_ptr_d;
            ex_gntd_q     <= ex_gntd_d;
            mem_data_q    <= mem_data_d;
            aux_data_q    <= aux_data_d;
        end
    end

    logic [1:0] excl_cnt;
    logic       shr_any;
    logic       data_ok;

    // Summarise the cache states for the coherence invariants.
    always_comb begin
        excl_cnt = 2'd0;
        shr_any  = 1'b0;
        data_ok  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (cache_state_q[k] == ST_E) begin
                excl_cnt = excl_cnt + 2'd1;
            end
            if (cache_state_q[k] == ST_S) begin
                shr_any = 1'b1;
            end
            if (cache_state_q[k] != ST_I && cache_data_q[k] != aux_data_q) begin
                data_ok = 1'b0;
            end
        end
    end

    a_single_excl: assert property (@(posedge clock) disable iff (reset) excl_cnt <= 2'd1);
    a_excl_no_shr: assert property (@(posedge clock) disable iff (reset) !(excl_cnt != 2'd0 && shr_any));
    a_mem_current: assert property (@(posedge clock) disable iff (reset) ex_gntd_q || mem_data_q == aux_data_q);
    a_cache_data:  assert property (@(posedge clock) disable iff (reset) data_ok);

endmodule

// File: tb/tb_german_system.sv
// tb_german_system: directed vector table plus randomized rule streams for german_system.
// Latency: every select is applied for one clock and its effect is checked 1 time unit after the edge.
// Backpressure: not applicable; the design has no flow control.
module tb_german_system;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] io_en_a;

    german_system dut (
        .clock   (clock),
        .reset   (reset),
        .io_en_a (io_en_a)
    );

    always #5 clock = ~clock;

    // Field identifiers for the reference model and the probes
    localparam int F_CSTATE = 0;
    localparam int F_CDATA  = 1;
    localparam int F_C1CMD  = 2;
    localparam int F_C1DATA = 3;
    localparam int F_C2CMD  = 4;
    localparam int F_C2DATA = 5;
    localparam int F_C3CMD  = 6;
    localparam int F_C3DATA = 7;
    localparam int F_INV    = 8;
    localparam int F_SHR    = 9;
    localparam int F_CURCMD = 10;  // fields from here on are global, node index 0
    localparam int F_CURPTR = 11;
    localparam int F_EXG    = 12;
    localparam int F_MEM    = 13;
    localparam int F_AUX    = 14;
    localparam int NF       = 15;

    localparam int K_RST  = 0;
    localparam int K_STEP = 1;
    localparam int K_CHK  = 2;

    typedef struct {
        int    kind;
        int    sel;
        int    fld;
        int    node;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs[$];
    int   m[NF][3];
    int   tests = 0;
    int   fails = 0;

    function automatic int probe(int f, int n);
        case (f)
            F_CSTATE: return int'(dut.cache_state_q[n]);
            F_CDATA:  return int'(dut.cache_data_q[n]);
            F_C1CMD:  return int'(dut.chan1_cmd_q[n]);
            F_C1DATA: return int'(dut.chan1_data_q[n]);
            F_C2CMD:  return int'(dut.chan2_cmd_q[n]);
            F_C2DATA: return int'(dut.chan2_data_q[n]);
            F_C3CMD:  return int'(dut.chan3_cmd_q[n]);
            F_C3DATA: return int'(dut.chan3_data_q[n]);
            F_INV:    return int'(dut.inv_set_q[n]);
            F_SHR:    return int'(dut.shr_set_q[n]);
            F_CURCMD: return int'(dut.cur_cmd_q);
            F_CURPTR: return int'(dut.cur_ptr_q);
            F_EXG:    return int'(dut.ex_gntd_q);
            F_MEM:    return int'(dut.mem_data_q);
            F_AUX:    return int'(dut.aux_data_q);
            default:  return -1;
        endcase
    endfunction

    function automatic void model_reset();
        for (int f = 0; f < NF; f++)
            for (int n = 0; n < 3; n++)
                m[f][n] = 0;
    endfunction

    // Protocol rules written directly from the rule table (cmd: 0 Empty,1 ReqS,2 ReqE,3 Inv,4 InvAck,5 GntS,6 GntE).
    function automatic void model_apply(int sel);
        int r;
        int i;
        if (sel >= 30) return;
        r = sel / 3;
        i = sel % 3;
        case (r)
            0: if (m[F_C1CMD][i] == 0 && m[F_CSTATE][i] == 0) m[F_C1CMD][i] = 1;
            1: if (m[F_C1CMD][i] == 0 && m[F_CSTATE][i] != 2) m[F_C1CMD][i] = 2;
            2: if (m[F_CURCMD][0] == 0 && m[F_C1CMD][i] inside {1, 2}) begin
                m[F_CURCMD][0] = m[F_C1CMD][i];
                m[F_CURPTR][0] = i;
                m[F_C1CMD][i]  = 0;
                for (int j = 0; j < 3; j++) m[F_INV][j] = m[F_SHR][j];
            end
            3: if (m[F_C2CMD][i] == 0 && m[F_INV][i] == 1 &&
                   (m[F_CURCMD][0] == 2 || (m[F_CURCMD][0] == 1 && m[F_EXG][0] == 1))) begin
                m[F_C2CMD][i] = 3;
                m[F_INV][i]   = 0;
            end
            4: if (m[F_C2CMD][i] == 3 && m[F_C3CMD][i] == 0) begin
                m[F_C2CMD][i] = 0;
                m[F_C3CMD][i] = 4;
                if (m[F_CSTATE][i] == 2) m[F_C3DATA][i] = m[F_CDATA][i];
                m[F_CSTATE][i] = 0;
            end
            5: if (m[F_C3CMD][i] == 4 && m[F_CURCMD][0] != 0) begin
                m[F_C3CMD][i] = 0;
                m[F_SHR][i]   = 0;
                if (m[F_EXG][0] == 1) begin
                    m[F_EXG][0] = 0;
                    m[F_MEM][0] = m[F_C3DATA][i];
                end
            end
            6: if (m[F_CURCMD][0] == 1 && m[F_CURPTR][0] == i && m[F_C2CMD][i] == 0 && m[F_EXG][0] == 0) begin
                m[F_C2CMD][i]  = 5;
                m[F_C2DATA][i] = m[F_MEM][0];
                m[F_SHR][i]    = 1;
                m[F_CURCMD][0] = 0;
            end
            7: if (m[F_CURCMD][0] == 2 && m[F_CURPTR][0] == i && m[F_C2CMD][i] == 0 && m[F_EXG][0] == 0 &&
                   m[F_SHR][0] + m[F_SHR][1] + m[F_SHR][2] == 0) begin
                m[F_C2CMD][i]  = 6;
                m[F_C2DATA][i] = m[F_MEM][0];
                m[F_SHR][i]    = 1;
                m[F_EXG][0]    = 1;
                m[F_CURCMD][0] = 0;
            end
            8: if (m[F_C2CMD][i] inside {5, 6}) begin
                m[F_CSTATE][i] = (m[F_C2CMD][i] == 5) ? 1 : 2;
                m[F_CDATA][i]  = m[F_C2DATA][i];
                m[F_C2CMD][i]  = 0;
            end
            9: if (m[F_CSTATE][i] == 2) begin
                m[F_AUX][0]   = (m[F_AUX][0] + 1) % 3;
                m[F_CDATA][i] = m[F_AUX][0];
            end
            default: ;
        endcase
    endfunction

    // Compare every register with the model, then check the coherence invariants on the DUT state.
    task automatic compare_all(input string tag);
        int bad_f;
        int bad_n;
        int act;
        int n_e;
        int n_s;
        bit data_ok;
        bad_f = -1;
        bad_n = 0;
        act   = 0;
        tests++;
        for (int f = 0; f < NF; f++) begin
            for (int n = 0; n < ((f >= F_CURCMD) ? 1 : 3); n++) begin
                if (bad_f < 0 && probe(f, n) != m[f][n]) begin
                    bad_f = f;
                    bad_n = n;
                    act   = probe(f, n);
                end
            end
        end
        if (bad_f >= 0) begin
            fails++;
            $display("FAIL %s: field %0d node %0d got %0d expected %0d", tag, bad_f, bad_n, act, m[bad_f][bad_n]);
        end
        tests++;
        n_e = 0;
        n_s = 0;
        data_ok = 1'b1;
        for (int n = 0; n < 3; n++) begin
            if (probe(F_CSTATE, n) == 2) n_e++;
            if (probe(F_CSTATE, n) == 1) n_s++;
            if (probe(F_CSTATE, n) != 0 && probe(F_CDATA, n) != probe(F_AUX, 0)) data_ok = 1'b0;
        end
        if (n_e > 1 || (n_e > 0 && n_s > 0) || !data_ok ||
            (probe(F_EXG, 0) == 0 && probe(F_MEM, 0) != probe(F_AUX, 0))) begin
            fails++;
            $display("FAIL %s invariants: E=%0d S=%0d data_ok=%0d mem=%0d aux=%0d exg=%0d required E<=1, no S with E, data_ok=1, mem==aux when exg=0",
                     tag, n_e, n_s, data_ok, probe(F_MEM, 0), probe(F_AUX, 0), probe(F_EXG, 0));
        end
    endtask

    task automatic step(input int sel);
        io_en_a = 5'(sel);
        @(posedge clock);
        #1;
        model_apply(sel);
        io_en_a = 5'd31;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        io_en_a = 5'd31;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic void add(int kind, int sel, int fld, int node, int exp, string name);
        vecs.push_back('{kind, sel, fld, node, exp, name});
    endfunction

    initial begin
        reset   = 1'b1;
        io_en_a = 5'd31;
        model_reset();

        // T1: ReqS from node 0 accepted by the directory
        add(K_CHK, 0, F_CURCMD, 0, 0, "rst_curcmd");
        add(K_CHK, 0, F_CSTATE, 1, 0, "rst_cache1");
        add(K_STEP, 0, 0, 0, 0, "T1_reqs");
        add(K_CHK, 0, F_C1CMD, 0, 1, "T1_chan1_reqs");
        add(K_STEP, 6, 0, 0, 0, "T1_recvreq");
        add(K_CHK, 0, F_CURCMD, 0, 1, "T1_curcmd");
        add(K_CHK, 0, F_CURPTR, 0, 0, "T1_curptr");
        add(K_CHK, 0, F_C1CMD, 0, 0, "T1_chan1_empty");
        // T2: shared grant to node 0
        add(K_STEP, 18, 0, 0, 0, "T2_gnts");
        add(K_CHK, 0, F_C2CMD, 0, 5, "T2_chan2_gnts");
        add(K_CHK, 0, F_C2DATA, 0, 0, "T2_chan2_data");
        add(K_CHK, 0, F_SHR, 0, 1, "T2_shr0");
        add(K_CHK, 0, F_CURCMD, 0, 0, "T2_curcmd");
        add(K_STEP, 24, 0, 0, 0, "T2_recvgnt");
        add(K_CHK, 0, F_CSTATE, 0, 1, "T2_cache0_s");
        add(K_CHK, 0, F_CDATA, 0, 0, "T2_cache0_data");
        // T3: exclusive grant to node 1, then a store
        add(K_RST, 0, 0, 0, 0, "T3_reset");
        add(K_STEP, 4, 0, 0, 0, "T3_reqe");
        add(K_CHK, 0, F_C1CMD, 1, 2, "T3_chan1_reqe");
        add(K_STEP, 7, 0, 0, 0, "T3_recvreq");
        add(K_CHK, 0, F_CURPTR, 0, 1, "T3_curptr");
        add(K_STEP, 22, 0, 0, 0, "T3_gnte");
        add(K_CHK, 0, F_C2CMD, 1, 6, "T3_chan2_gnte");
        add(K_CHK, 0, F_EXG, 0, 1, "T3_exgntd");
        add(K_STEP, 25, 0, 0, 0, "T3_recvgnt");
        add(K_CHK, 0, F_CSTATE, 1, 2, "T3_cache1_e");
        add(K_STEP, 28, 0, 0, 0, "T3_store");
        add(K_CHK, 0, F_CDATA, 1, 1, "T3_cache1_data");
        add(K_CHK, 0, F_AUX, 0, 1, "T3_aux");
        // T4: node 2 takes exclusive ownership away from node 1
        add(K_STEP, 5, 0, 0, 0, "T4_reqe2");
        add(K_STEP, 8, 0, 0, 0, "T4_recvreq2");
        add(K_CHK, 0, F_INV, 1, 1, "T4_invset1");
        add(K_STEP, 10, 0, 0, 0, "T4_sendinv1");
        add(K_CHK, 0, F_C2CMD, 1, 3, "T4_chan2_inv");
        add(K_STEP, 13, 0, 0, 0, "T4_invack1");
        add(K_CHK, 0, F_C3CMD, 1, 4, "T4_chan3_invack");
        add(K_CHK, 0, F_C3DATA, 1, 1, "T4_chan3_data");
        add(K_STEP, 16, 0, 0, 0, "T4_recvinvack1");
        add(K_CHK, 0, F_CSTATE, 1, 0, "T4_cache1_i");
        add(K_CHK, 0, F_EXG, 0, 0, "T4_exgntd_clr");
        add(K_CHK, 0, F_MEM, 0, 1, "T4_memdata");
        add(K_CHK, 0, F_SHR, 1, 0, "T4_shr1_clr");
        add(K_STEP, 23, 0, 0, 0, "T4_gnte2");
        add(K_CHK, 0, F_C2CMD, 2, 6, "T4_chan2_gnte2");
        add(K_CHK, 0, F_C2DATA, 2, 1, "T4_chan2_data2");
        // T5: false guards and empty selects change nothing
        add(K_STEP, 27, 0, 0, 0, "T5_store_inv");
        add(K_CHK, 0, F_AUX, 0, 1, "T5_aux_hold");
        add(K_STEP, 30, 0, 0, 0, "T5_sel30");
        add(K_STEP, 31, 0, 0, 0, "T5_sel31");
        add(K_STEP, 6, 0, 0, 0, "T5_recvreq_empty");
        add(K_CHK, 0, F_CURPTR, 0, 2, "T5_curptr_hold");
        add(K_STEP, 22, 0, 0, 0, "T5_gnte_no_req");
        add(K_CHK, 0, F_C2CMD, 1, 0, "T5_chan2_1_empty");

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        compare_all("reset_state");

        foreach (vecs[k]) begin
            case (vecs[k].kind)
                K_RST: begin
                    do_reset();
                    compare_all(vecs[k].name);
                end
                K_STEP: begin
                    step(vecs[k].sel);
                    compare_all(vecs[k].name);
                end
                default: begin
                    tests++;
                    if (probe(vecs[k].fld, vecs[k].node) != vecs[k].exp) begin
                        fails++;
                        $display("FAIL %s: got %0d expected %0d", vecs[k].name,
                                 probe(vecs[k].fld, vecs[k].node), vecs[k].exp);
                    end
                end
            endcase
        end

        // T6: reset asserted in the middle of a cycle clears state at once and blocks rules
        do_reset();
        step(0);
        step(6);
        step(18);
        step(24);
        compare_all("T6_before_reset");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("T6_async_clear");
        io_en_a = 5'd0;
        @(posedge clock);
        #1;
        compare_all("T6_reset_held");
        reset   = 1'b0;
        io_en_a = 5'd31;

        // Random rule streams with occasional resets
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
            end else begin
                step(int'($urandom_range(0, 31)));
            end
            compare_all("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
